// File: rtl/bp_me_wormhole_link_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bp_me_wormhole_link_arbiter                                     |
// | Purpose  : Round-robin, wormhole-aware arbiter that shares one outgoing    |
// |            ready_and link among several requesting links. The grant is     |
// |            taken on a header flit and held until the last flit of the      |
// |            packet, so packets never interleave.                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bp_me_wormhole_link_arbiter #(
  parameter int num_src_p    = 2,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 7,
  parameter int len_width_p  = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_src_p*flit_width_p-1:0] link_data_i,
  input  logic [num_src_p-1:0]              link_v_i,
  output logic [num_src_p-1:0]              link_ready_and_o,
  output logic [flit_width_p-1:0]           link_data_o,
  output logic                              link_v_o,
  input  logic                              link_ready_and_i,
  output logic [num_src_p-1:0]              grant_o,
  output logic                              busy_o
);

  localparam int ptr_w = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  localparam int rem_w = len_width_p + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e                  state, state_n;
  logic [ptr_w-1:0]        rr_ptr, rr_ptr_n;
  logic [ptr_w-1:0]        owner, owner_n;
  logic [rem_w-1:0]        rem, rem_n;
  // Set while the owner's header was presented but not yet accepted.
  logic                    hdr_pend, hdr_pend_n;
  logic [ptr_w-1:0]        sel;
  logic                    any_v;
  logic [ptr_w-1:0]        mux_idx;
  logic [flit_width_p-1:0] cur_data;
  logic [len_width_p-1:0]  hdr_len;
  logic [flit_width_p-1:0] src_data [num_src_p];

  // Advance a source index by one, wrapping at num_src_p-1.
  function automatic logic [ptr_w-1:0] inc_ptr(input logic [ptr_w-1:0] p);
    inc_ptr = (p == ptr_w'(num_src_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  for (genvar g = 0; g < num_src_p; g++) begin : g_unpack
    assign src_data[g] = link_data_i[g*flit_width_p +: flit_width_p];
  end

  // Round-robin pick: first valid source scanning upward from rr_ptr.
  // The scan runs backwards so the lowest offset is the last one written.
  always_comb begin : p_select
    int idx;
    sel   = rr_ptr;
    any_v = 1'b0;
    idx   = 0;
    for (int k = num_src_p - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= num_src_p) idx = idx - num_src_p;
      if (link_v_i[idx]) begin
        sel   = ptr_w'(idx);
        any_v = 1'b1;
      end
    end
  end

  assign mux_idx  = (state == LOCK) ? owner : sel;
  assign cur_data = src_data[mux_idx];
  assign hdr_len  = cur_data[cord_width_p +: len_width_p];

  // Next-state and output decode; all outputs stay gated while in reset.
  always_comb begin
    state_n          = state;
    rr_ptr_n         = rr_ptr;
    owner_n          = owner;
    rem_n            = rem;
    hdr_pend_n       = hdr_pend;
    link_v_o         = 1'b0;
    link_ready_and_o = '0;
    grant_o          = '0;
    busy_o           = 1'b0;
    link_data_o      = cur_data;
    if (!reset_i) begin
      case (state)
        IDLE: begin
          if (any_v) begin
            link_v_o              = 1'b1;
            link_ready_and_o[sel] = link_ready_and_i;
            grant_o[sel]          = 1'b1;
            if (link_ready_and_i) begin
              if (hdr_len == '0) begin
                rr_ptr_n = inc_ptr(sel);
              end else begin
                state_n    = LOCK;
                owner_n    = sel;
                rem_n      = rem_w'(hdr_len);
                hdr_pend_n = 1'b0;
              end
            end else begin
              // Freeze the choice so the presented header cannot change.
              state_n    = LOCK;
              owner_n    = sel;
              rem_n      = rem_w'(hdr_len) + rem_w'(1);
              hdr_pend_n = 1'b1;
            end
          end
        end
        LOCK: begin
          busy_o                  = 1'b1;
          grant_o[owner]          = 1'b1;
          link_v_o                = link_v_i[owner];
          link_ready_and_o[owner] = link_ready_and_i;
          if (link_v_i[owner] && link_ready_and_i) begin
            rem_n      = rem - rem_w'(1);
            hdr_pend_n = 1'b0;
            if (rem == rem_w'(1)) begin
              state_n  = IDLE;
              rr_ptr_n = inc_ptr(owner);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      rem      <= '0;
      hdr_pend <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      rem      <= rem_n;
      hdr_pend <= hdr_pend_n;
    end
  end

`ifndef SYNTHESIS
  a_hdr_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (state == LOCK && hdr_pend) |-> link_v_i[owner]);
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(grant_o));
  a_rem_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (state == LOCK && link_v_i[owner] && link_ready_and_i) |-> (rem != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wormhole_link_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bp_me_wormhole_link_arbiter                                  |
// | Purpose  : Directed self-checking bench for the wormhole link arbiter      |
// |            with three sources.                                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bp_me_wormhole_link_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic [N*W-1:0]  link_data_i = '0;
  logic [N-1:0]    link_v_i = '0;
  logic [N-1:0]    link_ready_and_o;
  logic [W-1:0]    link_data_o;
  logic            link_v_o;
  logic            link_ready_and_i = 1'b0;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  int errors = 0;
  int checks = 0;

  // Per-source flit queues feeding the DUT inputs.
  logic [W-1:0] q [N][8];
  int qn [N];
  int qi [N];

  typedef struct packed {
    logic [2:0]  vm;
    logic        rdy;
    logic        lvo;
    logic [2:0]  gnt;
    logic [2:0]  lro;
    logic        busy;
    logic [31:0] data;
  } vec_t;

  bp_me_wormhole_link_arbiter #(
    .num_src_p   (N),
    .flit_width_p(W),
    .cord_width_p(7),
    .len_width_p (4)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .link_data_i     (link_data_i),
    .link_v_i        (link_v_i),
    .link_ready_and_o(link_ready_and_o),
    .link_data_o     (link_data_o),
    .link_v_o        (link_v_o),
    .link_ready_and_i(link_ready_and_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o)
  );

  // 10-unit clock.
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] hdr(input int s, input int len, input int n);
    return {4'hA, 4'(s), 8'(n), 5'd0, 4'(len), 7'(s + 10)};
  endfunction

  function automatic logic [31:0] body(input int s, input int n);
    return {4'hB, 4'(s), 8'(n), 16'h0};
  endfunction

  task automatic clear_q();
    for (int k = 0; k < N; k++) begin
      qn[k] = 0;
      qi[k] = 0;
    end
  endtask

  task automatic push(input int s, input logic [31:0] d);
    q[s][qn[s]] = d;
    qn[s] = qn[s] + 1;
  endtask

  // Present the head of each enabled queue, then let combinational outputs settle.
  task automatic drive(input logic [2:0] vm, input logic rdy);
    for (int k = 0; k < N; k++) begin
      if (vm[k] && qi[k] < qn[k]) begin
        link_v_i[k] = 1'b1;
        link_data_i[k*W +: W] = q[k][qi[k]];
      end else begin
        link_v_i[k] = 1'b0;
        link_data_i[k*W +: W] = 32'hDEAD_0000 | 32'(k);
      end
    end
    link_ready_and_i = rdy;
    #1;
  endtask

  // Pop any flit that handshakes this cycle, then move past the clock edge.
  task automatic advance();
    for (int k = 0; k < N; k++)
      if (link_v_i[k] && link_ready_and_o[k]) qi[k] = qi[k] + 1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    link_v_i = 3'b111;
    link_ready_and_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== 8'b0) begin
      errors++;
      $display("FAIL reset_gated: got v=%b g=%b r=%b busy=%b, want all 0",
               link_v_o, grant_o, link_ready_and_o, busy_o);
    end
    reset_i = 1'b0;
    link_v_i = 3'b000;
    #1;
    checks++;
    if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== 8'b0) begin
      errors++;
      $display("FAIL reset_idle: got v=%b g=%b r=%b busy=%b, want all 0",
               link_v_o, grant_o, link_ready_and_o, busy_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  // Single-flit packet from src1, then contention shows rr_ptr moved to 2.
  task automatic test_len0();
    vec_t v [5];
    clear_q();
    push(1, hdr(1, 0, 0)); push(1, hdr(1, 0, 1));
    push(0, hdr(0, 0, 1)); push(2, hdr(2, 0, 1));
    v[0] = '{3'b010, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, hdr(1, 0, 0)};
    v[1] = '{3'b111, 1'b1, 1'b1, 3'b100, 3'b100, 1'b0, hdr(2, 0, 1)};
    v[2] = '{3'b111, 1'b1, 1'b1, 3'b001, 3'b001, 1'b0, hdr(0, 0, 1)};
    v[3] = '{3'b111, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, hdr(1, 0, 1)};
    v[4] = '{3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      drive(v[i].vm, v[i].rdy);
      checks++;
      if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== {v[i].lvo, v[i].gnt, v[i].lro, v[i].busy}) begin
        errors++;
        $display("FAIL len0 ctl cyc%0d: got v=%b g=%b r=%b busy=%b, want v=%b g=%b r=%b busy=%b",
                 i, link_v_o, grant_o, link_ready_and_o, busy_o, v[i].lvo, v[i].gnt, v[i].lro, v[i].busy);
      end
      if (v[i].lvo) begin
        checks++;
        if (link_data_o !== v[i].data) begin
          errors++;
          $display("FAIL len0 data cyc%0d: got %h want %h", i, link_data_o, v[i].data);
        end
      end
      advance();
    end
  endtask

  // Continuous single-flit traffic from all sources; starts with rr_ptr=2.
  task automatic test_rotation();
    vec_t v [8];
    clear_q();
    for (int n = 0; n < 2; n++) begin
      push(0, hdr(0, 0, n)); push(1, hdr(1, 0, n));
    end
    for (int n = 0; n < 3; n++) push(2, hdr(2, 0, n));
    v[0] = '{3'b111, 1'b1, 1'b1, 3'b100, 3'b100, 1'b0, hdr(2, 0, 0)};
    v[1] = '{3'b111, 1'b1, 1'b1, 3'b001, 3'b001, 1'b0, hdr(0, 0, 0)};
    v[2] = '{3'b111, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, hdr(1, 0, 0)};
    v[3] = '{3'b111, 1'b1, 1'b1, 3'b100, 3'b100, 1'b0, hdr(2, 0, 1)};
    v[4] = '{3'b111, 1'b1, 1'b1, 3'b001, 3'b001, 1'b0, hdr(0, 0, 1)};
    v[5] = '{3'b111, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, hdr(1, 0, 1)};
    v[6] = '{3'b111, 1'b1, 1'b1, 3'b100, 3'b100, 1'b0, hdr(2, 0, 2)};
    v[7] = '{3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(v[i].vm, v[i].rdy);
      checks++;
      if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== {v[i].lvo, v[i].gnt, v[i].lro, v[i].busy}) begin
        errors++;
        $display("FAIL rotation ctl cyc%0d: got v=%b g=%b r=%b busy=%b, want v=%b g=%b r=%b busy=%b",
                 i, link_v_o, grant_o, link_ready_and_o, busy_o, v[i].lvo, v[i].gnt, v[i].lro, v[i].busy);
      end
      if (v[i].lvo) begin
        checks++;
        if (link_data_o !== v[i].data) begin
          errors++;
          $display("FAIL rotation data cyc%0d: got %h want %h", i, link_data_o, v[i].data);
        end
      end
      advance();
    end
  endtask

  // Two 3-flit packets requested together; rr_ptr=0.
  task automatic test_back_to_back();
    vec_t v [7];
    clear_q();
    push(0, hdr(0, 2, 0)); push(0, body(0, 1)); push(0, body(0, 2));
    push(2, hdr(2, 2, 0)); push(2, body(2, 1)); push(2, body(2, 2));
    v[0] = '{3'b101, 1'b1, 1'b1, 3'b001, 3'b001, 1'b0, hdr(0, 2, 0)};
    v[1] = '{3'b101, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1, body(0, 1)};
    v[2] = '{3'b101, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1, body(0, 2)};
    v[3] = '{3'b101, 1'b1, 1'b1, 3'b100, 3'b100, 1'b0, hdr(2, 2, 0)};
    v[4] = '{3'b101, 1'b1, 1'b1, 3'b100, 3'b100, 1'b1, body(2, 1)};
    v[5] = '{3'b101, 1'b1, 1'b1, 3'b100, 3'b100, 1'b1, body(2, 2)};
    v[6] = '{3'b101, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      drive(v[i].vm, v[i].rdy);
      checks++;
      if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== {v[i].lvo, v[i].gnt, v[i].lro, v[i].busy}) begin
        errors++;
        $display("FAIL b2b ctl cyc%0d: got v=%b g=%b r=%b busy=%b, want v=%b g=%b r=%b busy=%b",
                 i, link_v_o, grant_o, link_ready_and_o, busy_o, v[i].lvo, v[i].gnt, v[i].lro, v[i].busy);
      end
      if (v[i].lvo) begin
        checks++;
        if (link_data_o !== v[i].data) begin
          errors++;
          $display("FAIL b2b data cyc%0d: got %h want %h", i, link_data_o, v[i].data);
        end
      end
      advance();
    end
  endtask

  // Header held under backpressure while a second source arrives; rr_ptr=0.
  task automatic test_backpressure();
    vec_t v [8];
    clear_q();
    push(0, hdr(0, 1, 0)); push(0, body(0, 1));
    push(1, hdr(1, 0, 0));
    v[0] = '{3'b001, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0, hdr(0, 1, 0)};
    v[1] = '{3'b001, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1, hdr(0, 1, 0)};
    v[2] = '{3'b011, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1, hdr(0, 1, 0)};
    v[3] = '{3'b011, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1, hdr(0, 1, 0)};
    v[4] = '{3'b011, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1, hdr(0, 1, 0)};
    v[5] = '{3'b011, 1'b1, 1'b1, 3'b001, 3'b001, 1'b1, body(0, 1)};
    v[6] = '{3'b011, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, hdr(1, 0, 0)};
    v[7] = '{3'b011, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      drive(v[i].vm, v[i].rdy);
      checks++;
      if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== {v[i].lvo, v[i].gnt, v[i].lro, v[i].busy}) begin
        errors++;
        $display("FAIL bp ctl cyc%0d: got v=%b g=%b r=%b busy=%b, want v=%b g=%b r=%b busy=%b",
                 i, link_v_o, grant_o, link_ready_and_o, busy_o, v[i].lvo, v[i].gnt, v[i].lro, v[i].busy);
      end
      if (v[i].lvo) begin
        checks++;
        if (link_data_o !== v[i].data) begin
          errors++;
          $display("FAIL bp data cyc%0d: got %h want %h", i, link_data_o, v[i].data);
        end
      end
      advance();
    end
  endtask

  // Owner src1 bubbles mid-packet while src0 waits; rr_ptr=2.
  task automatic test_bubble();
    vec_t v [9];
    clear_q();
    push(1, hdr(1, 3, 0)); push(1, body(1, 1)); push(1, body(1, 2)); push(1, body(1, 3));
    push(0, hdr(0, 0, 0));
    v[0] = '{3'b010, 1'b1, 1'b1, 3'b010, 3'b010, 1'b0, hdr(1, 3, 0)};
    v[1] = '{3'b010, 1'b1, 1'b1, 3'b010, 3'b010, 1'b1, body(1, 1)};
    v[2] = '{3'b001, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 32'h0};
    v[3] = '{3'b001, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 32'h0};
    v[4] = '{3'b001, 1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 32'h0};
    v[5] = '{3'b011, 1'b1, 1'b1, 3'b010, 3'b010, 1'b1, body(1, 2)};
    v[6] = '{3'b011, 1'b1, 1'b1, 3'b010, 3'b010, 1'b1, body(1, 3)};
    v[7] = '{3'b011, 1'b1, 1'b1, 3'b001, 3'b001, 1'b0, hdr(0, 0, 0)};
    v[8] = '{3'b011, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      drive(v[i].vm, v[i].rdy);
      checks++;
      if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== {v[i].lvo, v[i].gnt, v[i].lro, v[i].busy}) begin
        errors++;
        $display("FAIL bubble ctl cyc%0d: got v=%b g=%b r=%b busy=%b, want v=%b g=%b r=%b busy=%b",
                 i, link_v_o, grant_o, link_ready_and_o, busy_o, v[i].lvo, v[i].gnt, v[i].lro, v[i].busy);
      end
      if (v[i].lvo) begin
        checks++;
        if (link_data_o !== v[i].data) begin
          errors++;
          $display("FAIL bubble data cyc%0d: got %h want %h", i, link_data_o, v[i].data);
        end
      end
      advance();
    end
  endtask

  // Reset in LOCK with rem=3 abandons the packet; arbitration restarts at src0.
  task automatic test_reset_mid_packet();
    clear_q();
    push(2, hdr(2, 4, 0)); push(2, body(2, 1)); push(2, body(2, 2));
    push(0, hdr(0, 0, 0));
    // rr_ptr=1 here: src2 is first valid in scan order.
    drive(3'b100, 1'b1);
    checks++;
    if ({link_v_o, grant_o, busy_o} !== {1'b1, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid hdr: got v=%b g=%b busy=%b, want v=1 g=100 busy=0",
               link_v_o, grant_o, busy_o);
    end
    advance();
    drive(3'b100, 1'b1);
    checks++;
    if ({link_v_o, grant_o, busy_o, link_data_o} !== {1'b1, 3'b100, 1'b1, body(2, 1)}) begin
      errors++;
      $display("FAIL rst_mid body: got v=%b g=%b busy=%b d=%h, want v=1 g=100 busy=1 d=%h",
               link_v_o, grant_o, busy_o, link_data_o, body(2, 1));
    end
    advance();
    reset_i = 1'b1;
    drive(3'b101, 1'b1);
    checks++;
    if ({link_v_o, grant_o, link_ready_and_o, busy_o} !== 8'b0) begin
      errors++;
      $display("FAIL rst_mid gated: got v=%b g=%b r=%b busy=%b, want all 0",
               link_v_o, grant_o, link_ready_and_o, busy_o);
    end
    advance();
    reset_i = 1'b0;
    clear_q();
    push(0, hdr(0, 0, 0));
    push(2, hdr(2, 0, 1));
    drive(3'b101, 1'b1);
    checks++;
    if ({link_v_o, grant_o, link_ready_and_o, busy_o, link_data_o} !==
        {1'b1, 3'b001, 3'b001, 1'b0, hdr(0, 0, 0)}) begin
      errors++;
      $display("FAIL rst_mid restart: got v=%b g=%b r=%b busy=%b d=%h, want v=1 g=001 r=001 busy=0 d=%h",
               link_v_o, grant_o, link_ready_and_o, busy_o, link_data_o, hdr(0, 0, 0));
    end
    advance();
    drive(3'b101, 1'b1);
    checks++;
    if ({link_v_o, grant_o, busy_o} !== {1'b1, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid next: got v=%b g=%b busy=%b, want v=1 g=100 busy=0",
               link_v_o, grant_o, busy_o);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_len0();
    test_rotation();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
